alu_result_accumulator: RTL
===========================

Name: alu_result_accumulator

Overview:
- Sequential stage directly downstream of the sum/product selector, which produces a (2*p_width+1)-bit combinational result.
- Accepts a burst of p_count selector results over a valid/ready handshake and accumulates them into a running sum.
- Signals completion with a one-cycle done pulse, then holds the final sum for the next stage or the lab board display.

Parameters:
- p_width, 1, operand MSB index of the upstream selector; data input is 2*p_width+1 bits wide.
- p_count, 4, number of results per burst; legal range 1..255.
- p_acc_width, 8, accumulator width in bits; must be >= 2*p_width+1.

Ports:
- i_w_clk  input  1  clock; all state changes on the rising edge.
- i_w_rst_n  input  1  asynchronous, active-low reset.
- i_w_start  input  1  single-cycle request to begin a new burst.
- i_w_data  input  2*p_width+1  result from the upstream selector.
- i_w_valid  input  1  i_w_data is valid this cycle.
- o_w_ready  output  1  block accepts i_w_data this cycle.
- o_w_acc  output  p_acc_width  running or final sum (registered).
- o_w_cnt  output  8  number of results accepted in the current burst (registered).
- o_w_busy  output  1  high while in ACC.
- o_w_done  output  1  one-cycle pulse after the last accept.

Behaviour:
- Reset (async, i_w_rst_n=0):
  - state=IDLE; o_w_acc=0; o_w_cnt=0; o_w_done=0; o_w_busy=0; o_w_ready=0.
  - Applies immediately, including mid-burst; the partial sum is discarded.
- States: IDLE, ACC, DONE (2-bit encoding: IDLE=0, ACC=1, DONE=2; code 3 returns to IDLE).
- IDLE:
  - o_w_ready=0; o_w_acc holds the previous final sum.
  - i_w_start=1 -> next cycle: state=ACC, o_w_acc=0, o_w_cnt=0.
- ACC:
  - o_w_ready=1 and o_w_busy=1 (both decoded from state).
  - An accept is a cycle with i_w_valid=1 and o_w_ready=1.
  - On accept: o_w_acc <= o_w_acc + zero-extended i_w_data, modulo 2^p_acc_width; o_w_cnt <= o_w_cnt+1.
  - When the accept takes o_w_cnt to p_count, the next state is DONE.
  - i_w_valid=0 cycles stall the burst with no change and no timeout.
  - i_w_start is ignored in ACC.
- DONE:
  - o_w_done=1 for exactly one cycle; o_w_ready=0; then unconditional return to IDLE.
  - i_w_start in DONE is ignored; a new start must arrive while in IDLE.
- Latency:
  - o_w_acc reflects an accept on the following cycle.
  - o_w_done rises the cycle after the final accept.
  - Minimum burst time is 1 (start) + p_count + 1 (DONE) cycles.
- p_count=1: a single accept goes directly to DONE.
- i_w_data is sampled only on an accept; X on i_w_data when not accepting must not affect state.

Optional Feature:
- ACC_SATURATE_EN defined:
  - The adder computes at p_acc_width+1 bits.
  - On carry-out, o_w_acc clamps to all ones and stays saturated for the rest of the burst.
- Not defined: plain modular wrap-around.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared header/package alu_acc_pkg:
  - state encodings ST_IDLE, ST_ACC, ST_DONE;
  - state width constant;
  - counter width constant (8).
- One natural sub-module: burst_counter.
  - Clear/enable inputs, terminal-count output.
  - Compares against p_count; its terminal count drives the ACC->DONE transition.
- The adder and saturation logic stay in the top module.

Test Plan (p_width=1, p_count=4, p_acc_width=4):
- Reset, then start, then data 1,2,3,4 with valid every cycle -> o_w_acc=10, o_w_cnt=4, o_w_done high exactly 1 cycle, 6 cycles from start to done.
- Data 7,7,7,7 -> o_w_acc=12 (28 mod 16) without the macro; o_w_acc=15 with ACC_SATURATE_EN.
- Valid gaps: data 5,_,_,1,_,2,3 -> o_w_acc=11 only after the 4th accept; the done pulse is delayed accordingly.
- Start pulses during ACC and during DONE -> no restart, sum unaffected, state returns to IDLE after DONE.
- Assert i_w_rst_n=0 after 2 accepts -> all outputs 0 asynchronously (before the next edge); a new start gives a clean burst.
- p_count=1 build, start then data 6 -> o_w_acc=6, o_w_done on the next cycle.

Source files
------------

// File: rtl/alu_result_accumulator_pkg.sv
// Shared definitions for the ALU result accumulator: FSM state encoding and
// the widths of the state register and the burst counter.
package alu_acc_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 8;

    // Code 3 is unused; the FSM treats it as IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_accumulator_if.sv
// Input handshake between the sum/product selector and the accumulator.
// master drives start/data/valid, slave (the accumulator) returns ready.
interface alu_result_accumulator_if #(
    parameter int p_width = 1
);
    logic               i_w_start;
    logic [2*p_width:0] i_w_data;
    logic               i_w_valid;
    logic               o_w_ready;

    modport master (
        output i_w_start,
        output i_w_data,
        output i_w_valid,
        input  o_w_ready
    );

    modport slave (
        input  i_w_start,
        input  i_w_data,
        input  i_w_valid,
        output o_w_ready
    );
endinterface

// File: rtl/alu_result_accumulator_burst_counter.sv
// Counts accepted results within a burst. o_w_last flags that the next
// accept will be the p_count-th one, so the FSM can leave ACC on that accept.
module burst_counter
    import alu_acc_pkg::*;
#(
    parameter int p_count = 4
) (
    input  logic             i_w_clk,
    input  logic             i_w_rst_n,
    input  logic             i_w_clear,
    input  logic             i_w_enable,
    output logic [CNT_W-1:0] o_w_cnt,
    output logic             o_w_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(p_count - 1);

    // Accept counter: cleared at burst start, advanced once per accept.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            o_w_cnt <= '0;
        end else if (i_w_clear) begin
            o_w_cnt <= '0;
        end else if (i_w_enable) begin
            o_w_cnt <= o_w_cnt + 1'b1;
        end
    end

    assign o_w_last = (o_w_cnt == LAST_CNT);

endmodule

// File: rtl/alu_result_accumulator.sv
// Accumulates a burst of p_count selector results into a running sum and
// pulses o_w_done once the burst completes; the final sum is held in IDLE.
// Build option: define ACC_SATURATE_EN to clamp the sum at all ones instead
// of wrapping modulo 2^p_acc_width.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for i_w_start, holding last final sum
// ACC     | accepting results, ready/busy high
// DONE    | one-cycle completion pulse, then back to IDLE
module alu_result_accumulator
    import alu_acc_pkg::*;
#(
    parameter int p_width     = 1,
    parameter int p_count     = 4,
    parameter int p_acc_width = 8
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_rst_n,
    alu_result_accumulator_if.slave bus,
    output logic [p_acc_width-1:0]  o_w_acc,
    output logic [CNT_W-1:0]        o_w_cnt,
    output logic                    o_w_busy,
    output logic                    o_w_done
);

    localparam int EXT_W = p_acc_width + 1;

    state_t           state;
    logic             accept;
    logic             start_burst;
    logic             last;
    logic [EXT_W-1:0] sum_ext;
    logic [p_acc_width-1:0] acc_next;

    assign accept      = bus.i_w_valid && (state == ST_ACC);
    assign start_burst = bus.i_w_start && (state == ST_IDLE);

    assign bus.o_w_ready = (state == ST_ACC);
    assign o_w_busy      = (state == ST_ACC);
    assign o_w_done      = (state == ST_DONE);

    // One extra bit keeps the carry-out visible for the saturating build.
    assign sum_ext = {1'b0, o_w_acc} + EXT_W'(bus.i_w_data);

`ifdef ACC_SATURATE_EN
    // Once clamped at all ones, any further nonzero add carries again, so
    // the sum stays saturated for the rest of the burst without a flag.
    assign acc_next = sum_ext[p_acc_width] ? {p_acc_width{1'b1}}
                                           : sum_ext[p_acc_width-1:0];
`else
    assign acc_next = sum_ext[p_acc_width-1:0];
`endif

    burst_counter #(
        .p_count (p_count)
    ) u_burst_counter (
        .i_w_clk    (i_w_clk),
        .i_w_rst_n  (i_w_rst_n),
        .i_w_clear  (start_burst),
        .i_w_enable (accept),
        .o_w_cnt    (o_w_cnt),
        .o_w_last   (last)
    );

    // Burst sequencing and accumulator register; data only sampled on accept.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state   <= ST_IDLE;
            o_w_acc <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_w_start) begin
                        state   <= ST_ACC;
                        o_w_acc <= '0;
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        o_w_acc <= acc_next;
                        if (last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
